sampling_vae: RTL and testbench

SAMPLING_VAE -- requirements
Module: sampling_vae

---
 rtl/sampling_pkg.sv | 21 ++
 rtl/sampling_lfsr.sv | 32 +++
 rtl/sampling_vae.sv | 96 +++++++++
 tb/tb_sampling_vae.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/sampling_pkg.sv
// Shared fixed-point and LFSR constants for the sampling VAE block.
package sampling_pkg;

    localparam int unsigned BITSIZE_DEF = 32;
    localparam int unsigned FRAC_DEF    = 27;
    localparam logic [31:0] SAT_MAX     = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_MIN     = 32'h8000_0000;

    // Feedback taps at bits 31, 21, 1 and 0.
    localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;
    localparam logic [31:0] SEED_STEP   = 32'h1234_5679;
    localparam int unsigned EPS_MSB     = 27;

    // An all-zero LFSR would lock up, so a zero seed is forced to 1.
    function automatic logic [31:0] chan_seed(logic [31:0] base, int unsigned idx);
        logic [31:0] s;
        s = base + SEED_STEP * 32'(idx);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

endpackage

// File: rtl/sampling_lfsr.sv
// 32-bit Fibonacci LFSR with advance enable; reset loads the seed.
module sampling_lfsr
    import sampling_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        adv_i,
    output logic [31:0] state_o
);

    logic [31:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (adv_i) begin
            state_d = {state_q[30:0], ^(state_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/sampling_vae.sv
// Reparameterisation sampler: per channel z = mu + sigma * eps with LFSR noise,
// saturating add, one registered result per valid input.
module sampling_vae
    import sampling_pkg::*;
#(
    parameter int          N_input  = 2,
    parameter int          M_output = 2,
    parameter int          BITSIZE  = BITSIZE_DEF,
    parameter int          FRAC     = FRAC_DEF,
    parameter logic [31:0] SEED     = 32'hACE1_ACE1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [N_input*BITSIZE-1:0]    ac,
    input  logic [N_input*BITSIZE-1:0]    ad,
    output logic                          out_valid,
    output logic [M_output*BITSIZE-1:0]   a,
    output logic [M_output*BITSIZE-1:0]   epsilon
);

    if (M_output != N_input) begin : g_param_check
        $error("sampling_vae: M_output must equal N_input");
    end

    localparam logic [BITSIZE-1:0] SatMax =
        (BITSIZE == 32) ? BITSIZE'(SAT_MAX) : {1'b0, {(BITSIZE-1){1'b1}}};
    localparam logic [BITSIZE-1:0] SatMin =
        (BITSIZE == 32) ? BITSIZE'(SAT_MIN) : {1'b1, {(BITSIZE-1){1'b0}}};

    logic [N_input*BITSIZE-1:0] a_calc, eps_calc;

    logic                       out_valid_q, out_valid_d;
    logic [N_input*BITSIZE-1:0] a_q, a_d;
    logic [N_input*BITSIZE-1:0] eps_q, eps_d;

    for (genvar i = 0; i < N_input; i++) begin : g_chan
        logic [31:0]                 lfsr_state;
        logic signed [BITSIZE-1:0]   mu, sigma, eps, prod_sh;
        logic signed [2*BITSIZE-1:0] prod;
        logic [BITSIZE:0]            sum;

        sampling_lfsr #(
            .SEED(chan_seed(SEED, i))
        ) u_lfsr (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .adv_i  (in_valid),
            .state_o(lfsr_state)
        );

        assign mu    = ac[i*BITSIZE +: BITSIZE];
        assign sigma = ad[i*BITSIZE +: BITSIZE];

        // Sign-extend the low 28 state bits: noise in [-1.0, 1.0) in Q4.27.
        assign eps = BITSIZE'($signed(lfsr_state << (31 - EPS_MSB)) >>> (31 - EPS_MSB));

        assign prod    = sigma * eps;
        assign prod_sh = BITSIZE'(prod >>> FRAC);

        // One guard bit exposes signed overflow of the add.
        assign sum = {mu[BITSIZE-1], mu} + {prod_sh[BITSIZE-1], prod_sh};

        assign a_calc[i*BITSIZE +: BITSIZE] =
            (sum[BITSIZE] != sum[BITSIZE-1]) ? (sum[BITSIZE] ? SatMin : SatMax)
                                             : sum[BITSIZE-1:0];
        assign eps_calc[i*BITSIZE +: BITSIZE] = eps;
    end

    always_comb begin
        out_valid_d = in_valid;
        a_d         = a_q;
        eps_d       = eps_q;
        if (in_valid) begin
            a_d   = a_calc;
            eps_d = eps_calc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            a_q         <= '0;
            eps_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            a_q         <= a_d;
            eps_q       <= eps_d;
        end
    end

    assign out_valid = out_valid_q;
    assign a         = a_q;
    assign epsilon   = eps_q;

endmodule

// File: tb/tb_sampling_vae.sv
// Randomised bench for sampling_vae against an arithmetic reference model.
module tb_sampling_vae;

    localparam int N = 2;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic [N*W-1:0] ac = '0;
    logic [N*W-1:0] ad = '0;
    logic           out_valid;
    logic [N*W-1:0] a;
    logic [N*W-1:0] epsilon;

    always #5 clk = ~clk;

    sampling_vae #(
        .N_input (N),
        .M_output(N),
        .BITSIZE (W),
        .FRAC    (27),
        .SEED    (32'hACE1_ACE1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .ac       (ac),
        .ad       (ad),
        .out_valid(out_valid),
        .a        (a),
        .epsilon  (epsilon)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_state [N];
    logic [31:0] e_a     [N];
    logic [31:0] e_eps   [N];
    logic        e_valid;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] seed_of(input int i);
        logic [31:0] s;
        s = 32'hACE1_ACE1 + 32'(i) * 32'h1234_5679;
        return (s == 0) ? 32'h1 : s;
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_state[i] = seed_of(i);
            e_a[i]     = '0;
            e_eps[i]   = '0;
        end
        e_valid = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".valid"}, 64'(out_valid), 64'(e_valid));
        for (int i = 0; i < N; i++) begin
            check_eq($sformatf("%s.a%0d", tag, i), 64'(a[i*W +: W]), 64'(e_a[i]));
            check_eq($sformatf("%s.eps%0d", tag, i), 64'(epsilon[i*W +: W]), 64'(e_eps[i]));
        end
    endtask

    // Called just after a falling edge; applies inputs across one rising edge.
    task automatic drive(input string tag, input logic v, input logic [N*W-1:0] ac_v,
                         input logic [N*W-1:0] ad_v);
        int     mu, sg, ep, pt;
        longint prod, sum;
        in_valid = v;
        ac       = ac_v;
        ad       = ad_v;
        if (v) begin
            for (int i = 0; i < N; i++) begin
                mu   = int'(ac_v[i*W +: W]);
                sg   = int'(ad_v[i*W +: W]);
                ep   = int'(m_state[i][27:0]);
                if (m_state[i][27]) ep = ep - (1 << 28);
                prod = longint'(sg) * longint'(ep);
                pt   = int'(prod >>> 27);
                sum  = longint'(mu) + longint'(pt);
                if (sum > 64'sd2147483647) sum = 64'sd2147483647;
                if (sum < -64'sd2147483648) sum = -64'sd2147483648;
                e_a[i]     = 32'(sum);
                e_eps[i]   = 32'(ep);
                m_state[i] = lfsr_next(m_state[i]);
            end
        end
        e_valid = v;
        @(negedge clk);
        check_outputs(tag);
    endtask

    logic [31:0] eps_seen[$];
    int          pulses;
    int          dups;

    initial begin
        model_reset();
        #2;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Zero sigma passes mu straight through; first noise word is fixed.
        drive("zero_sigma", 1'b1, {32'h1B70_A3D7, 32'h2D33_3333}, '0);
        check_eq("first_eps0", 64'(epsilon[31:0]), 64'hFCE1_ACE1);
        check_eq("pass_mu0", 64'(a[31:0]), 64'h2D33_3333);

        drive("typical", 1'b1, {32'h2D33_3333, 32'h1B70_A3D7}, {32'h110A_3D70, 32'h070A_3D70});

        for (int k = 0; k < 6; k++) begin
            drive("sat_pos", 1'b1, {N{32'h7FFF_FFFF}}, {N{32'h7FFF_FFFF}});
        end
        for (int k = 0; k < 6; k++) begin
            drive("sat_neg", 1'b1, {N{32'h8000_0000}}, {N{32'h7FFF_FFFF}});
        end

        pulses = 0;
        eps_seen.delete();
        for (int k = 0; k < 16; k++) begin
            drive("burst", 1'b1, {$urandom, $urandom}, {$urandom, $urandom});
            if (out_valid) pulses++;
            eps_seen.push_back(epsilon[31:0]);
        end
        check_eq("burst_pulses", 64'(pulses), 64'd16);
        dups = 0;
        for (int i = 0; i < 16; i++)
            for (int j = i + 1; j < 16; j++)
                if (eps_seen[i] == eps_seen[j]) dups++;
        check_eq("burst_distinct", 64'(dups), 64'd0);

        for (int k = 0; k < 3; k++) begin
            drive("idle", 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
        end
        drive("after_idle", 1'b1, {$urandom, $urandom}, {$urandom, $urandom});

        // Reset between edges while a sample is being presented.
        drive("pre_rst", 1'b1, {$urandom, $urandom}, {$urandom, $urandom});
        in_valid = 1'b1;
        ac = {$urandom, $urandom};
        ad = {$urandom, $urandom};
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(negedge clk);
        check_outputs("held_rst");
        rst_n    = 1'b1;
        in_valid = 1'b0;
        drive("restart", 1'b1, {$urandom, $urandom}, {$urandom, $urandom});
        check_eq("restart_eps0", 64'(epsilon[31:0]), 64'hFCE1_ACE1);

        for (int k = 0; k < 200; k++) begin
            drive("rand", 1'($urandom_range(0, 3) != 0), {$urandom, $urandom},
                  {$urandom, $urandom});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
